// File: rtl/test_inputs_pkg.sv
// Shared constants and window decode for the scripted player-1 input generator.
// Frame numbers are inclusive window bounds on the frame counter.
package test_inputs_pkg;

   localparam int unsigned CNT_W = 16;

   typedef logic [CNT_W-1:0] frame_t;

   localparam int unsigned JOY_RIGHT = 0;
   localparam int unsigned JOY_LEFT  = 1;
   localparam int unsigned JOY_DOWN  = 2;
   localparam int unsigned JOY_UP    = 3;
   localparam int unsigned JOY_BTN1  = 4;
   localparam int unsigned JOY_BTN2  = 5;
   localparam int unsigned JOY_BTN3  = 6;
   localparam int unsigned OUT_START = 7;
   localparam int unsigned OUT_COIN  = 8;

   localparam frame_t COIN_START  = 16'd100;
   localparam frame_t COIN_END    = 16'd104;
   localparam frame_t START_START = 16'd150;
   localparam frame_t START_END   = 16'd154;
   localparam frame_t RIGHT_START = 16'd200;
   localparam frame_t RIGHT_END   = 16'd299;
   localparam frame_t BTN1_START  = 16'd300;
   localparam frame_t BTN1_END    = 16'd309;
   localparam frame_t LEFT_START  = 16'd310;
   localparam frame_t LEFT_END    = 16'd409;
   localparam frame_t BTN2_START  = 16'd410;
   localparam frame_t BTN2_END    = 16'd419;
   localparam frame_t DOWN_START  = 16'd420;
   localparam frame_t DOWN_END    = 16'd469;
   localparam frame_t UP_START    = 16'd470;
   localparam frame_t UP_END      = 16'd519;
   localparam frame_t BTN3_START  = 16'd520;
   localparam frame_t BTN3_END    = 16'd529;

   typedef struct packed {
      logic       coin;
      logic       start;
      logic [6:0] joy;
   } ctrl_t;

   // One active-low term per window; overlapping windows simply AND together.
   function automatic logic [8:0] win_mask(frame_t f, frame_t s, frame_t e, int unsigned b);
      return (f >= s && f <= e) ? ~(9'd1 << b) : '1;
   endfunction

   function automatic ctrl_t decode(frame_t f);
      logic [8:0] m;
      m = win_mask(f, COIN_START,  COIN_END,  OUT_COIN)
        & win_mask(f, START_START, START_END, OUT_START)
        & win_mask(f, RIGHT_START, RIGHT_END, JOY_RIGHT)
        & win_mask(f, BTN1_START,  BTN1_END,  JOY_BTN1)
        & win_mask(f, LEFT_START,  LEFT_END,  JOY_LEFT)
        & win_mask(f, BTN2_START,  BTN2_END,  JOY_BTN2)
        & win_mask(f, DOWN_START,  DOWN_END,  JOY_DOWN)
        & win_mask(f, UP_START,    UP_END,    JOY_UP)
        & win_mask(f, BTN3_START,  BTN3_END,  JOY_BTN3);
      return ctrl_t'(m);
   endfunction

endpackage

// File: rtl/test_inputs_edge.sv
// LVBL falling-edge detector; the history register clears to 0 so a blank
// already in progress at reset/restart release is not counted.
module test_inputs_edge (
   input  logic clk,
   input  logic rst_n,
   input  logic i_clr,
   input  logic i_lvbl,
   output logic o_tick
);

   logic r_lvbl_l;

   always_ff @(posedge clk) begin
      if (!rst_n || i_clr) r_lvbl_l <= 1'b0;
      else                 r_lvbl_l <= i_lvbl;
   end

   assign o_tick = r_lvbl_l & ~i_lvbl;

endmodule

// File: rtl/test_inputs.sv
// Scripted player-1 input generator: counts frames on LVBL falling edges and
// replays a fixed coin/start/joystick sequence from the frame count.
module test_inputs
   import test_inputs_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       loop_rst,
   input  logic       LVBL,
   output logic [6:0] game_joystick1,
   output logic       button_1p,
   output logic       coin_left
);

   logic   w_tick;
   frame_t r_frame_cnt;
   ctrl_t  r_ctrl;

   test_inputs_edge u_edge (
      .clk    (clk),
      .rst_n  (rst_n),
      .i_clr  (loop_rst),
      .i_lvbl (LVBL),
      .o_tick (w_tick)
   );

   // Outputs decode the registered count, so they trail the count by one clock.
   always_ff @(posedge clk) begin
      if (!rst_n || loop_rst) begin
         r_frame_cnt <= '0;
         r_ctrl      <= '1;
      end else begin
         if (w_tick && r_frame_cnt != '1) r_frame_cnt <= r_frame_cnt + 1'b1;
         r_ctrl <= decode(r_frame_cnt);
      end
   end

   assign game_joystick1 = r_ctrl.joy;
   assign button_1p      = r_ctrl.start;
   assign coin_left      = r_ctrl.coin;

endmodule

// File: tb/tb_test_inputs.sv
// Randomized-timing bench for test_inputs with a frame-level reference model
// and a per-cycle compare of all nine outputs.
module tb_test_inputs;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       loop_rst = 1'b0;
   logic       LVBL = 1'b1;
   logic [6:0] game_joystick1;
   logic       button_1p;
   logic       coin_left;

   int vectors = 0;
   int miscompares = 0;

   test_inputs dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .loop_rst       (loop_rst),
      .LVBL           (LVBL),
      .game_joystick1 (game_joystick1),
      .button_1p      (button_1p),
      .coin_left      (coin_left)
   );

   always #5 clk = ~clk;

   // Script table: output bit {coin=8, start=7, joy[6:0]}, first and last frame.
   int wbit   [9] = '{8,   7,   0,   4,   1,   5,   2,   3,   6};
   int wstart [9] = '{100, 150, 200, 300, 310, 410, 420, 470, 520};
   int wend   [9] = '{104, 154, 299, 309, 409, 419, 469, 519, 529};

   function automatic logic [8:0] model_out(int f);
      logic [8:0] v;
      v = '1;
      for (int k = 0; k < 9; k++)
         if (f >= wstart[k] && f <= wend[k]) v[wbit[k]] = 1'b0;
      return v;
   endfunction

   // Reference: frame count from LVBL falling edges, outputs lag one clock.
   int         mc = 0;
   logic       mprev = 1'b0;
   logic [8:0] mexp = '1;
   logic       cmp_en = 1'b0;

   always @(posedge clk) begin
      if (!rst_n || loop_rst) begin
         mc    = 0;
         mprev = 1'b0;
         mexp  = '1;
      end else begin
         mexp = model_out(mc);
         if (mprev && !LVBL && mc < 65535) mc = mc + 1;
         mprev = LVBL;
      end
   end

   always @(negedge clk) begin
      if (cmp_en) begin
         vectors++;
         if ({coin_left, button_1p, game_joystick1} !== mexp) begin
            miscompares++;
            $display("FAIL cycle_cmp t=%0t frame=%0d: got %h expected %h",
                     $time, mc, {coin_left, button_1p, game_joystick1}, mexp);
         end
      end
   end

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   task automatic clk1();
      @(posedge clk);
      #1;
   endtask

   task automatic send_frame();
      LVBL = 1'b0;
      repeat ($urandom_range(1, 4)) clk1();
      LVBL = 1'b1;
      repeat ($urandom_range(2, 4)) clk1();
   endtask

   task automatic frames_to(input int target);
      while (mc < target) send_frame();
   endtask

   function automatic logic [8:0] outs();
      return {coin_left, button_1p, game_joystick1};
   endfunction

   int first_low [9];
   int last_low  [9];

   initial begin
      // Model pins.
      check("model_f99",  32'(model_out(99)),  32'h1FF);
      check("model_f100", 32'(model_out(100)), 32'h0FF);
      check("model_f250", 32'(model_out(250)), 32'h1FE);
      check("model_f530", 32'(model_out(530)), 32'h1FF);

      // Reset then idle.
      rst_n = 1'b0;
      LVBL  = 1'b1;
      clk1();
      cmp_en = 1'b1;
      repeat (3) clk1();
      rst_n = 1'b1;
      repeat (2) clk1();
      check("reset_cnt",  32'(dut.r_frame_cnt), 32'd0);
      check("reset_outs", 32'(outs()), 32'h1FF);

      // Coin window.
      frames_to(99);
      LVBL = 1'b0;
      clk1();
      check("coin_cnt100", 32'(dut.r_frame_cnt), 32'd100);
      check("coin_lag1",   32'(coin_left), 32'd1);
      clk1();
      check("coin_on",     32'(coin_left), 32'd0);
      LVBL = 1'b1;
      repeat (3) clk1();
      frames_to(104);
      check("coin_f104",   32'(coin_left), 32'd0);
      send_frame();
      check("coin_off",    32'(coin_left), 32'd1);

      // Long LVBL low counts once.
      begin
         int c0;
         c0 = mc;
         LVBL = 1'b0;
         repeat (50) clk1();
         LVBL = 1'b1;
         repeat (3) clk1();
         check("long_low", 32'(dut.r_frame_cnt), 32'(c0 + 1));
      end

      // Restart race at frame 250.
      frames_to(250);
      check("f250_right", 32'(game_joystick1[0]), 32'd0);
      LVBL     = 1'b0;
      loop_rst = 1'b1;
      clk1();
      check("race_cnt", 32'(dut.r_frame_cnt), 32'd0);
      clk1();
      check("race_joy", 32'(game_joystick1), 32'h7F);
      loop_rst = 1'b0;
      LVBL     = 1'b1;
      repeat (2) clk1();
      frames_to(200);
      check("rerun_right", 32'(game_joystick1[0]), 32'd0);

      // Mid-script reset released while LVBL is low.
      frames_to(210);
      rst_n = 1'b0;
      LVBL  = 1'b0;
      repeat (4) clk1();
      rst_n = 1'b1;
      repeat (3) clk1();
      check("rst_low_cnt", 32'(dut.r_frame_cnt), 32'd0);
      LVBL = 1'b1;
      repeat (2) clk1();
      send_frame();
      check("rst_first_frame", 32'(dut.r_frame_cnt), 32'd1);

      // Full script with per-frame log.
      loop_rst = 1'b1;
      repeat (2) clk1();
      loop_rst = 1'b0;
      repeat (2) clk1();
      for (int k = 0; k < 9; k++) begin
         first_low[k] = -1;
         last_low[k]  = -1;
      end
      for (int f = 1; f <= 600; f++) begin
         send_frame();
         for (int k = 0; k < 9; k++) begin
            if (outs()[wbit[k]] == 1'b0) begin
               if (first_low[k] < 0) first_low[k] = f;
               last_low[k] = f;
            end
         end
      end
      for (int k = 0; k < 9; k++) begin
         check($sformatf("win%0d_first", k), 32'(first_low[k]), 32'(wstart[k]));
         check($sformatf("win%0d_last", k),  32'(last_low[k]),  32'(wend[k]));
      end
      check("f600_outs", 32'(outs()), 32'h1FF);

      // Saturation.
      force dut.r_frame_cnt = 16'hFFFE;
      mc = 65534;
      clk1();
      release dut.r_frame_cnt;
      clk1();
      repeat (3) send_frame();
      check("sat_cnt",  32'(dut.r_frame_cnt), 32'hFFFF);
      check("sat_outs", 32'(outs()), 32'h1FF);

      cmp_en = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/test_inputs.md
TEST_INPUTS -- requirements
Module: test_inputs

Interface
REQ-001 clk  input  1  single system clock; every register in the block uses its rising edge.
REQ-002 rst_n  input  1  reset; synchronous and active-low.
REQ-003 loop_rst  input  1  active-high script restart, sampled synchronously; held high while ROM download is in progress.
REQ-004 LVBL  input  1  active-low vertical blank from video timing; one low pulse per frame.
REQ-005 game_joystick1  output  7  active-low player 1 controls: [0] right, [1] left, [2] down, [3] up, [4] button1, [5] button2, [6] button3.
REQ-006 button_1p  output  1  active-low player 1 start.
REQ-007 coin_left  output  1  active-low coin slot 1.

Function
REQ-008 The block SHALL register LVBL each clock into LVBL_l and detect a frame tick when LVBL_l=1 and LVBL=0.
REQ-009 The 16-bit frame counter SHALL increment by one on the clock edge where a frame tick is detected.
REQ-010 The counter SHALL saturate at 0xFFFF and never wrap.
REQ-011 All outputs SHALL be registered and SHALL be decoded from the counter value after its update.
- A counter change becomes visible on the outputs one clock later.
- That is two clocks after LVBL is first sampled low.
REQ-012 Default output state: all outputs at 1 (idle, nothing pressed).
REQ-013 Script table, frames inclusive; each output SHALL be low only inside its window:
- coin_left: 100-104
- button_1p: 150-154
- joy[0] right: 200-299
- joy[4] button1: 300-309
- joy[1] left: 310-409
- joy[5] button2: 410-419
- joy[2] down: 420-469
- joy[3] up: 470-519
- joy[6] button3: 520-529
REQ-014 Outside all windows, including frames 530 up to the saturated count, all outputs SHALL stay 1.
REQ-015 Windows do not overlap; the decode SHALL still be a bitwise AND of independent window terms, so any future overlap combines without priority.
REQ-016 While loop_rst=1, the block SHALL clear the counter to 0, force LVBL_l to 0 and drive all outputs to 1.
REQ-017 loop_rst=1 SHALL win over a simultaneous frame tick on the same edge.
REQ-018 After loop_rst falls, the script SHALL restart from frame 0.
REQ-019 A frame tick SHALL require a 1-to-0 LVBL transition; LVBL held low for many clocks SHALL count exactly once.

Reset
REQ-020 On a clock edge with rst_n=0, the block SHALL set the counter to 0, LVBL_l to 0 and all outputs to 1.
REQ-021 Because LVBL_l resets to 0, LVBL already low when reset is released SHALL NOT produce a spurious tick.
REQ-022 Reset asserted mid-script SHALL abort the script; after release, the script SHALL restart at frame 0.

Structure
REQ-023 A package test_inputs_pkg SHALL hold:
- the counter width (16);
- the joystick bit-index constants;
- every window start/end frame constant from REQ-013.
REQ-024 One sub-module, test_inputs_edge, SHALL implement the LVBL falling-edge detector with the REQ-008 and REQ-021 reset behaviour.
REQ-025 The window decode SHALL be a function in the package or in the module body.

Verification
REQ-026 Reset then idle: hold rst_n=0 for 4 clocks, then release with LVBL=1 -> all outputs 1 and counter 0.
REQ-027 Coin window: generate 100 LVBL pulses -> coin_left=0 two clocks after the 100th low sample; coin_left returns to 1 after the 105th pulse.
REQ-028 Long LVBL low: hold LVBL low for 50 clocks -> counter increments by exactly 1.
REQ-029 Restart race: at frame 250 (right pressed), assert loop_rst on the same edge as a tick -> counter=0 and game_joystick1=7'h7F on the next clock; re-reach frame 200 -> joy[0]=0.
REQ-030 Full script: generate 600 frames and log per-frame outputs -> each bit is low exactly inside its REQ-013 window; everything is 1 from frame 530 on.
REQ-031 Saturation: preload or force the counter to 0xFFFE and send 3 ticks -> counter holds at 0xFFFF and outputs stay 1.
